oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

Sprite-DMA initiator for the NES CPU bus. It snoops CPU writes to $4014. On such a write it halts the CPU and becomes bus master, copying 256 bytes from page $XX00–$XXFF to the PPU OAM data port $2004 as alternating read/write cycles. The memory/IO model answers these cycles as the responder, exactly as it answers the CPU. The block sits beside the CPU on the bus: in front of the memory model in both the reference-model and DUV halves of the bench, and later in the NES top.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer
- OAM_DATA_ADDR, 16'h2004, destination address of every DMA write
- XFER_LEN, 256, bytes per transfer (fixed; counter is 8 bits)

Ports:
- clk  input  1  system clock; everything in the block runs on its rising edge
- rst  input  1  asynchronous, active-high reset
- cpu_addr_i  input  16  CPU bus address (snooped)
- cpu_wr_i  input  1  CPU write strobe, 1 = write cycle this clock
- cpu_data_i  input  8  CPU write data (snooped)
- mem_data_i  input  8  read data returned by the memory model for the current DMA read
- cpu_rdy_o  output  1  0 = CPU halted; the CPU must not drive the bus
- dma_en_o  output  1  1 = DMA owns the bus this cycle; mux select for addr/rw/data
- dma_addr_o  output  16  DMA bus address
- dma_rw_o  output  1  1 = read, 0 = write
- dma_data_o  output  8  DMA write data
- dma_done_o  output  1  one-cycle pulse after the last write

## Operation
- Internal parity flop `par`: reset 0, toggles every clk. Cycles with par=0 are "get" (read-eligible).
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - Trigger = cpu_wr_i & (cpu_addr_i == DMA_REG_ADDR).
  - On trigger, latch page <= cpu_data_i, clear count and go to HALT.
- HALT: one dummy cycle with dma_en_o=0 and cpu_rdy_o=0.
  - Next state is READ if the next cycle's par=0, else ALIGN.
- ALIGN: one idle cycle with dma_en_o=0; next state is READ.
- READ:
  - dma_addr_o = {page, count}, dma_rw_o=1.
  - mem_data_i is captured into the byte latch at the clock edge ending the cycle.
  - Next state is WRITE.
- WRITE:
  - dma_addr_o = OAM_DATA_ADDR, dma_rw_o=0, dma_data_o = latch.
  - If count==8'hFF: go to IDLE and pulse dma_done_o. Else count <= count+1 and go to READ.
- Address arithmetic: only the low byte increments, and count stops at $FF, so there is no page carry (page $FF covers $FF00–$FFFF).
- Triggers while not IDLE are ignored; the halted CPU cannot generate them, and the bench checks this.
- Outputs in IDLE: cpu_rdy_o=1, dma_en_o=0, dma_addr_o=16'h0000, dma_rw_o=1, dma_data_o=8'h00, dma_done_o=0.
- In HALT/ALIGN the bus outputs hold their idle values with cpu_rdy_o=0.

## Timing
- All outputs are registered from state, so there is no combinational path from the inputs.
- The trigger is sampled at edge T. At T+1, cpu_rdy_o=0 and the state is HALT.
- Busy length (cpu_rdy_o low) is exactly 513 cycles (HALT + 512) or 514 cycles (with ALIGN).
- The first READ always lands on a par=0 cycle, and every READ stays on par=0.
- dma_done_o is high in the first IDLE cycle after the final WRITE; cpu_rdy_o returns to 1 in that same cycle.
- Read-data contract: mem_data_i must be valid before the edge that ends the READ cycle. The memory model responds within the cycle, as it does for CPU reads.
- Reset mid-transfer: outputs take their idle values asynchronously, state returns to IDLE, count and latch clear, and par clears. There is no dma_done_o pulse. OAM is left partially written.
- A trigger on the first clk edge after rst deasserts is accepted normally.

## Test plan
- Reset: rst=1 mid-cycle -> cpu_rdy_o=1, dma_en_o=0, dma_addr_o=$0000, dma_rw_o=1, dma_done_o=0 immediately, without waiting for a clk edge.
- Page $02 trigger on an even-par edge -> 513 busy cycles. Reads of $0200..$02FF each occur on a par=0 cycle and are each followed by a write to $2004 of that byte. With memory preloaded as byte[i]=i^$5A, OAM ends holding the same values. dma_done_o pulses once.
- Same transfer triggered one cycle later (odd alignment) -> ALIGN is entered and the transfer takes 514 busy cycles. The OAM result is identical.
- Page $FF -> reads end at $FFFF with no access to $0000 and no extra cycles; the final write goes to $2004.
- rst asserted after 100 cycles of DMA -> immediate idle outputs, no dma_done_o. A new $4014 write of $03 afterwards runs a full clean transfer.
- CPU write to $4015 or $2004 -> no trigger, cpu_rdy_o stays 1. Back-to-back $4014 writes of $02 then $03 on adjacent cycles -> only $02 is transferred, and the second write is ignored.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA initiator. Snoops CPU writes to the DMA register,
// halts the CPU and copies one 256-byte page to the OAM data port as
// alternating read/write bus cycles, with reads pinned to par=0 cycles.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_i,
    input  logic        cpu_wr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic [7:0]  mem_data_i,
    output logic        cpu_rdy_o,
    output logic        dma_en_o,
    output logic [15:0] dma_addr_o,
    output logic        dma_rw_o,
    output logic [7:0]  dma_data_o,
    output logic        dma_done_o
);

    // Index of the final byte; the 8-bit counter stops here, so no page carry.
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state_q, state_d;
    logic       par_q, par_d;
    logic [7:0] page_q, page_d;
    logic [7:0] count_q, count_d;
    logic [7:0] latch_q, latch_d;
    logic       done_q, done_d;
    logic       trigger;

    assign trigger = cpu_wr_i && (cpu_addr_i == DMA_REG_ADDR);

    // State and datapath registers; reset returns everything to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            par_q   <= 1'b0;
            page_q  <= 8'h00;
            count_q <= 8'h00;
            latch_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            par_q   <= par_d;
            page_q  <= page_d;
            count_q <= count_d;
            latch_q <= latch_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: HALT picks READ directly only if the next cycle is par=0.
    always_comb begin
        state_d = state_q;
        par_d   = ~par_q;
        page_d  = page_q;
        count_d = count_q;
        latch_d = latch_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    page_d  = cpu_data_i;
                    count_d = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
                state_d = par_q ? READ : ALIGN;
            end
            ALIGN: begin
                state_d = READ;
            end
            READ: begin
                latch_d = mem_data_i;
                state_d = WRITE;
            end
            WRITE: begin
                if (count_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    count_d = count_q + 8'h01;
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs decoded from registered state only; idle values elsewhere.
    always_comb begin
        cpu_rdy_o  = (state_q == IDLE);
        dma_en_o   = 1'b0;
        dma_addr_o = 16'h0000;
        dma_rw_o   = 1'b1;
        dma_data_o = 8'h00;
        dma_done_o = done_q;
        case (state_q)
            READ: begin
                dma_en_o   = 1'b1;
                dma_addr_o = {page_q, count_q};
            end
            WRITE: begin
                dma_en_o   = 1'b1;
                dma_addr_o = OAM_DATA_ADDR;
                dma_rw_o   = 1'b0;
                dma_data_o = latch_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: scoreboard bench. Stimulus pushes the expected bus
// transactions; a forked monitor pops and compares on every DMA-active or
// done cycle and records OAM writes.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr_i;
    logic        cpu_wr_i;
    logic [7:0]  cpu_data_i;
    logic [7:0]  mem_data_i;
    logic        cpu_rdy_o;
    logic        dma_en_o;
    logic [15:0] dma_addr_o;
    logic        dma_rw_o;
    logic [7:0]  dma_data_o;
    logic        dma_done_o;

    logic [7:0]  mem [65536];
    logic [7:0]  oam [256];
    logic [7:0]  oam_ptr;
    int          oam_writes;
    logic [27:0] exp_q [$];
    logic [27:0] mon_act;
    logic [27:0] mon_exp;
    logic        tb_par;
    int          checks = 0;
    int          passes = 0;

    oam_dma_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr_i (cpu_addr_i),
        .cpu_wr_i   (cpu_wr_i),
        .cpu_data_i (cpu_data_i),
        .mem_data_i (mem_data_i),
        .cpu_rdy_o  (cpu_rdy_o),
        .dma_en_o   (dma_en_o),
        .dma_addr_o (dma_addr_o),
        .dma_rw_o   (dma_rw_o),
        .dma_data_o (dma_data_o),
        .dma_done_o (dma_done_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference parity: 0 after reset, toggles every edge.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    // Memory model answers DMA reads within the cycle.
    always_comb mem_data_i = mem[dma_addr_o];

    function automatic logic [7:0] expData(input logic [7:0] page, input logic [7:0] idx);
        return idx ^ 8'h5A ^ (page - 8'h02);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got %h required %h at %0t", name, act, expv, $time);
    endtask

    // Expected word: {done, en, rw, addr, wdata, read_par}.
    task automatic pushXfer(input logic [7:0] page);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({1'b0, 1'b1, 1'b1, page, 8'(i), 8'h00, 1'b0});
            exp_q.push_back({1'b0, 1'b1, 1'b0, 16'h2004, expData(page, 8'(i)), 1'b0});
        end
        exp_q.push_back({1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0});
    endtask

    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] data);
        cpu_wr_i   = wr;
        cpu_addr_i = addr;
        cpu_data_i = data;
    endtask

    task automatic waitPar(input logic p);
        @(posedge clk); #1;
        for (int n = 0; n < 4 && tb_par != p; n++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clearOam();
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        oam_ptr    = 8'h00;
        oam_writes = 0;
    endtask

    // Full transfer: trigger in a cycle of parity p, optionally follow with a
    // second $4014 write, then measure busy length and check OAM contents.
    task automatic runXfer(input string name, input logic [7:0] page, input logic p,
                           input logic dbl, input int exp_busy);
        int busy;
        int errs;
        clearOam();
        pushXfer(page);
        waitPar(p);
        applyStimulus(1'b1, 16'h4014, page);
        @(posedge clk); #1;
        busy = 0;
        for (int n = 0; n < 1000; n++) begin
            if (cpu_rdy_o) break;
            busy++;
            if (n == 0 && dbl) applyStimulus(1'b1, 16'h4014, 8'h03);
            else               applyStimulus(1'b0, 16'h0000, 8'h00);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput({name, "_busy"}, busy, exp_busy);
        checkOutput({name, "_done_at_rdy"}, {31'd0, dma_done_o}, 32'd1);
        @(posedge clk); #1;
        checkOutput({name, "_queue_left"}, exp_q.size(), 0);
        checkOutput({name, "_done_cleared"}, {31'd0, dma_done_o}, 32'd0);
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (oam[i] !== expData(page, 8'(i))) errs++;
        checkOutput({name, "_oam_bad_bytes"}, errs, 0);
        checkOutput({name, "_oam_writes"}, oam_writes, 256);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = expData(8'(a >> 8), 8'(a));
        clearOam();
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 8'h00);

        // Monitor: compare every active bus or done cycle against the queue.
        fork
            forever begin
                @(negedge clk);
                if (!rst && (dma_en_o || dma_done_o)) begin
                    mon_act = {dma_done_o, dma_en_o, dma_rw_o, dma_addr_o,
                               dma_rw_o ? 8'h00 : dma_data_o,
                               (dma_en_o && dma_rw_o) ? tb_par : 1'b0};
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_bus", {4'd0, mon_act}, 32'd0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        checkOutput("bus_txn", {4'd0, mon_act}, {4'd0, mon_exp});
                    end
                    if (dma_en_o && !dma_rw_o && dma_addr_o == 16'h2004) begin
                        oam[oam_ptr] = dma_data_o;
                        oam_ptr      = oam_ptr + 8'h01;
                        oam_writes++;
                    end
                end
            end
        join_none

        #2;
        checkOutput("reset_idle", {13'd0, cpu_rdy_o, dma_en_o, dma_addr_o, dma_rw_o, dma_done_o},
                    {13'd0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        #10 rst = 1'b0;

        // Writes to other addresses must not start a transfer.
        waitPar(1'b0);
        applyStimulus(1'b1, 16'h4015, 8'h02);
        @(posedge clk); #1;
        applyStimulus(1'b1, 16'h2004, 8'h02);
        @(posedge clk); #1;
        applyStimulus(1'b0, 16'h0000, 8'h00);
        for (int k = 0; k < 3; k++) begin
            checkOutput("no_trigger_rdy_en", {30'd0, cpu_rdy_o, dma_en_o}, 32'd2);
            @(posedge clk); #1;
        end

        runXfer("page02_even", 8'h02, 1'b0, 1'b0, 513);
        runXfer("page02_odd", 8'h02, 1'b1, 1'b0, 514);
        runXfer("pageFF", 8'hFF, 1'b0, 1'b0, 513);
        runXfer("back_to_back", 8'h02, 1'b0, 1'b1, 513);

        // Reset in the middle of a transfer.
        clearOam();
        pushXfer(8'h02);
        waitPar(1'b0);
        applyStimulus(1'b1, 16'h4014, 8'h02);
        @(posedge clk); #1;
        applyStimulus(1'b0, 16'h0000, 8'h00);
        repeat (100) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_idle",
                    {5'd0, cpu_rdy_o, dma_en_o, dma_addr_o, dma_rw_o, dma_data_o, dma_done_o},
                    {5'd0, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("after_reset_rdy_done", {30'd0, cpu_rdy_o, dma_done_o}, 32'd2);
            @(posedge clk); #1;
        end
        runXfer("page03_after_reset", 8'h03, 1'b0, 1'b0, 513);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
